// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Instruction field positions, FSM state type, jump-condition helper
// Rev    : 1.0
// ============================================================================
package cpu_pkg;

  localparam int C_BIT_CI  = 15;
  localparam int C_BIT_A   = 12;
  localparam int C_BIT_ZX  = 11;
  localparam int C_BIT_NX  = 10;
  localparam int C_BIT_ZY  = 9;
  localparam int C_BIT_NY  = 8;
  localparam int C_BIT_F   = 7;
  localparam int C_BIT_NO  = 6;
  localparam int C_BIT_DA  = 5;
  localparam int C_BIT_DD  = 4;
  localparam int C_BIT_DM  = 3;
  localparam int C_BIT_JLT = 2;
  localparam int C_BIT_JEQ = 1;
  localparam int C_BIT_JGT = 0;

  typedef enum logic [0:0] {
    S_EXEC   = 1'b0,
    S_MEM_RD = 1'b1
  } state_t;

  // j = {lt, eq, gt}; positive means neither zero nor negative
  function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
    return (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hack_alu.sv
`default_nettype none
// ============================================================================
// Module : hack_alu
// Brief  : Combinational Hack ALU, DW bits wide, with zero/negative flags
// Rev    : 1.0
// ============================================================================
module hack_alu #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic          zx,
  input  logic          nx,
  input  logic          zy,
  input  logic          ny,
  input  logic          f,
  input  logic          no,
  output logic [DW-1:0] out,
  output logic          zr,
  output logic          ng
);

  logic [DW-1:0] w_x0, w_x1, w_y0, w_y1, w_fn;

  assign w_x0 = zx ? '0 : x;
  assign w_x1 = nx ? ~w_x0 : w_x0;
  assign w_y0 = zy ? '0 : y;
  assign w_y1 = ny ? ~w_y0 : w_y0;
  assign w_fn = f ? (w_x1 + w_y1) : (w_x1 & w_y1);
  assign out  = no ? ~w_fn : w_fn;
  assign zr   = (out == '0);
  assign ng   = out[DW-1];

endmodule
`default_nettype wire

// File: rtl/cpu_stall.sv
`default_nettype none
// ============================================================================
// Module : cpu_stall
// Brief  : Hack-style CPU core with fetch-valid and variable-latency M reads
// Rev    : 1.0
// ============================================================================
module cpu_stall
  import cpu_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   instruction,
  input  logic          instr_valid,
  input  logic [DW-1:0] inM,
  input  logic          inM_valid,
  output logic [DW-1:0] outM,
  output logic          writeM,
  output logic          readM,
  output logic [AW-1:0] addressM,
  output logic [AW-1:0] pc,
  output logic          retire
);

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_a, r_d;
  logic [AW-1:0] r_pc;

  logic          w_is_c, w_mread, w_commit, w_readm, w_jump, w_zr, w_ng;
  logic [DW-1:0] w_y, w_alu;
  logic          w_unused;

  assign w_is_c   = instruction[C_BIT_CI];
  assign w_mread  = w_is_c & instruction[C_BIT_A];
  assign w_y      = instruction[C_BIT_A] ? inM : r_a;
  // bits 14:13 of a C-instruction carry no meaning
  assign w_unused = ^instruction[14:13];

  hack_alu #(.DW(DW)) u_alu (
    .x   (r_d),
    .y   (w_y),
    .zx  (instruction[C_BIT_ZX]),
    .nx  (instruction[C_BIT_NX]),
    .zy  (instruction[C_BIT_ZY]),
    .ny  (instruction[C_BIT_NY]),
    .f   (instruction[C_BIT_F]),
    .no  (instruction[C_BIT_NO]),
    .out (w_alu),
    .zr  (w_zr),
    .ng  (w_ng)
  );

  assign w_jump = w_is_c & jump_taken(instruction[C_BIT_JLT:C_BIT_JGT], w_zr, w_ng);

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_readm     = 1'b0;
    case (r_state)
      S_EXEC: begin
        if (instr_valid) begin
          if (w_mread) begin
            w_readm     = 1'b1;
            w_state_nxt = S_MEM_RD;
          end else begin
            w_commit = 1'b1;
          end
        end
      end
      S_MEM_RD: begin
        w_readm = 1'b1;
        if (inM_valid) begin
          w_commit    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      default: w_state_nxt = S_EXEC;
    endcase
    if (rst) begin
      w_commit = 1'b0;
      w_readm  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EXEC;
      r_a     <= '0;
      r_d     <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_commit) begin
        if (!w_is_c) begin
          r_a  <= {{(DW-15){1'b0}}, instruction[14:0]};
          r_pc <= r_pc + 1'b1;
        end else begin
          if (instruction[C_BIT_DA]) r_a <= w_alu;
          if (instruction[C_BIT_DD]) r_d <= w_alu;
          // jump target is the A value from before this instruction
          r_pc <= w_jump ? r_a[AW-1:0] : r_pc + 1'b1;
        end
      end
    end
  end

  assign outM     = w_alu;
  assign writeM   = w_commit & w_is_c & instruction[C_BIT_DM];
  assign readM    = w_readm;
  assign addressM = r_a[AW-1:0];
  assign pc       = r_pc;
  assign retire   = w_commit;

endmodule
`default_nettype wire

// File: tb/tb_cpu_stall.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_stall
// Brief  : Directed self-checking bench; DW=16 and DW=24 cores run in lockstep
// Rev    : 1.0
// ============================================================================
module tb_cpu_stall;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [23:0] inM;
  logic        inM_valid;

  logic [15:0] outM16;
  logic        writeM16, readM16, retire16;
  logic [14:0] addr16, pc16;
  logic [23:0] outM24;
  logic        writeM24, readM24, retire24;
  logic [14:0] addr24, pc24;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_stall #(.DW(16), .AW(15)) u_dut16 (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .inM(inM[15:0]), .inM_valid(inM_valid), .outM(outM16), .writeM(writeM16),
    .readM(readM16), .addressM(addr16), .pc(pc16), .retire(retire16)
  );

  cpu_stall #(.DW(24), .AW(15)) u_dut24 (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .inM(inM), .inM_valid(inM_valid), .outM(outM24), .writeM(writeM24),
    .readM(readM24), .addressM(addr24), .pc(pc24), .retire(retire24)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the edge, checks happen 4 units after
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ins);
    instruction = ins;
    instr_valid = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; instruction = 16'hE308; instr_valid = 1'b1;
    inM = '0; inM_valid = 1'b0;
    repeat (2) step();
    #3;
    chk("rst_writeM", writeM16, 0);
    chk("rst_retire", retire16, 0);
    chk("rst_pc", pc16, 0);
    chk("rst_A", addr16, 0);
    chk("rst_D", outM16, 0);
    step();
    rst = 1'b0;

    // A=15 then D=A
    instruction = 16'h000F; instr_valid = 1'b1; #3;
    chk("aload_retire", retire16, 1);
    chk("aload_writeM", writeM16, 0);
    step();
    chk("aload_A", addr16, 15);
    chk("aload_pc", pc16, 1);
    instruction = 16'hEC10; #3;
    chk("dea_retire", retire16, 1);
    chk("dea_writeM", writeM16, 0);
    step();
    chk("dea_pc", pc16, 2);
    instruction = 16'hE308; instr_valid = 1'b0; #3;
    chk("dea_D", outM16, 15);
    chk("idle_writeM", writeM16, 0);
    chk("idle_retire", retire16, 0);

    // M=D at address 1
    step();
    issue(16'h0001);
    chk("mw_pc0", pc16, 3);
    instruction = 16'hE308; instr_valid = 1'b1; #3;
    chk("mw_writeM", writeM16, 1);
    chk("mw_addr", addr16, 1);
    chk("mw_outM", outM16, 15);
    chk("mw_retire", retire16, 1);
    step();
    chk("mw_pc", pc16, 4);
    instr_valid = 1'b0; #3;
    chk("mw_writeM_once", writeM16, 0);

    // D=M from address 5, valid on third readM cycle
    step();
    issue(16'h0005);
    instruction = 16'hFC10; instr_valid = 1'b1; inM_valid = 1'b0; #3;
    chk("rd_c1_readM", readM16, 1);
    chk("rd_c1_retire", retire16, 0);
    chk("rd_c1_writeM", writeM16, 0);
    step(); #3;
    chk("rd_c2_readM", readM16, 1);
    chk("rd_c2_retire", retire16, 0);
    chk("rd_c2_pc", pc16, 5);
    step();
    inM = 24'h000007; inM_valid = 1'b1; #3;
    chk("rd_c3_readM", readM16, 1);
    chk("rd_c3_retire", retire16, 1);
    chk("rd_c3_addr", addr16, 5);
    chk("rd_c3_writeM", writeM16, 0);
    step();
    inM_valid = 1'b0;
    chk("rd_pc", pc16, 6);
    instruction = 16'hE308; instr_valid = 1'b0; #3;
    chk("rd_D", outM16, 7);
    chk("rd_readM_off", readM16, 0);

    // JEQ taken with D=0, not taken with D=1
    step();
    issue(16'hEA90);
    issue(16'h0014);
    chk("jeq_pc0", pc16, 8);
    instruction = 16'hE302; instr_valid = 1'b1; #3;
    chk("jeq_retire", retire16, 1);
    step();
    chk("jeq_taken_pc", pc16, 20);
    issue(16'hEFD0);
    issue(16'h0014);
    issue(16'hE302);
    chk("jeq_not_taken_pc", pc16, 23);

    // fetch stall: a pending M-read word must not start while invalid
    instruction = 16'hFC10; instr_valid = 1'b0; inM_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("fs_readM", readM16, 0);
      chk("fs_writeM", writeM16, 0);
      chk("fs_retire", retire16, 0);
      step();
    end
    inM_valid = 1'b0;
    chk("fs_pc", pc16, 23);
    chk("fs_A", addr16, 20);
    instruction = 16'hE308; #3;
    chk("fs_D", outM16, 1);

    // DW=24: D=0x800000 via M, then D;JLT to 40
    step();
    issue(16'h0003);
    instruction = 16'hFC10; instr_valid = 1'b1; inM = 24'h800000; inM_valid = 1'b0;
    step();
    inM_valid = 1'b1;
    step();
    inM_valid = 1'b0;
    chk("w24_pc", pc24, 25);
    issue(16'h0028);
    instruction = 16'hE304; #3;
    chk("w24_D", outM24, 24'h800000);
    step();
    chk("w24_jlt_taken", pc24, 40);
    chk("w16_jlt_not_taken", pc16, 27);

    // reset while waiting in MEM_RD
    issue(16'h0009);
    instruction = 16'hFC10; instr_valid = 1'b1; inM_valid = 1'b0;
    step(); #3;
    chk("rr_readM_pre", readM16, 1);
    step();
    rst = 1'b1; inM_valid = 1'b1; #3;
    chk("rr_readM_rst", readM16, 0);
    chk("rr_writeM_rst", writeM16, 0);
    chk("rr_retire_rst", retire16, 0);
    step();
    rst = 1'b0; inM_valid = 1'b0; instr_valid = 1'b0; instruction = 16'hE308; #3;
    chk("rr_readM_exec", readM16, 0);
    chk("rr_writeM", writeM16, 0);
    chk("rr_pc", pc16, 0);
    chk("rr_A", addr16, 0);
    chk("rr_D", outM16, 0);
    chk("rr_pc24", pc24, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
